i2c_byte_master: RTL and testbench

I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

---
 rtl/i2c_byte_master_if.sv | 26 ++
 rtl/i2c_byte_master.sv | 142 ++++++++++++++
 tb/tb_i2c_byte_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_master_if.sv
// Handshake and pad-control bundle for i2c_byte_master.
// master: the byte engine itself; slave: the upstream sequencer plus the pad/bus side.
interface i2c_byte_master_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_start;
    logic       in_stop;
    logic       ack_valid;
    logic       ack_nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;
    logic       scl_i;

    modport master (
        input  in_valid, in_data, in_start, in_stop, sda_i, scl_i,
        output in_ready, ack_valid, ack_nack, busy, scl_oe, sda_oe
    );

    modport slave (
        output in_valid, in_data, in_start, in_stop, sda_i, scl_i,
        input  in_ready, ack_valid, ack_nack, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START/repeated START, 8 data bits MSB first, ACK slot, STOP or HOLD.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL in quarter q1 (sensed on scl_i).
module i2c_byte_master #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    i2c_byte_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, HOLD} state_t;
    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  q, q_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        stop_q, stop_n;
    logic        scl_n, sda_n, ack_valid_n;
    logic        accept, tick, phase_end, hold_q1;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_hist;
    assign hold_q1 = (q == 2'd1) && (state inside {START, DATA, ACK, STOP}) && (scl_hist != 2'b11);
`else
    assign hold_q1 = 1'b0;
`endif

    assign accept    = bus.in_valid && bus.in_ready;
    assign tick      = (cnt == CNT_MAX) && !hold_q1;
    assign phase_end = tick && (q == 2'd3);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        q_n       = q;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        stop_n    = stop_q;

        // HOLD keeps the timer running (saturated in q0) so the next phase's q0 absorbs the HOLD cycles.
        if (state != IDLE) begin
            if (tick && (state != HOLD || accept)) begin
                cnt_n = '0;
                q_n   = q + 2'd1;
            end else if (cnt != CNT_MAX) begin
                cnt_n = cnt + 16'd1;
            end
        end

        case (state)
            IDLE: if (accept) begin
                state_n   = START;
                shreg_n   = bus.in_data;
                stop_n    = bus.in_stop;
                bit_cnt_n = '0;
            end
            START: if (phase_end) begin
                state_n   = DATA;
                bit_cnt_n = '0;
            end
            DATA: if (phase_end) begin
                shreg_n = {shreg[6:0], 1'b0};
                if (bit_cnt == 3'd7) state_n = ACK;
                else bit_cnt_n = bit_cnt + 3'd1;
            end
            ACK: if (phase_end) state_n = stop_q ? STOP : HOLD;
            STOP: if (phase_end) state_n = IDLE;
            HOLD: if (accept) begin
                state_n   = bus.in_start ? START : DATA;
                shreg_n   = bus.in_data;
                stop_n    = bus.in_stop;
                bit_cnt_n = '0;
            end
            default: state_n = IDLE;
        endcase

        scl_n = 1'b0;
        sda_n = 1'b0;
        case (state_n)
            START: case (q_n)
                2'd0:    scl_n = bus.scl_oe;
                2'd2:    sda_n = 1'b1;
                2'd3:    begin scl_n = 1'b1; sda_n = 1'b1; end
                default: ;
            endcase
            DATA: begin
                scl_n = (q_n == 2'd0) || (q_n == 2'd3);
                sda_n = ~shreg_n[7];
            end
            ACK:  scl_n = (q_n == 2'd0) || (q_n == 2'd3);
            STOP: case (q_n)
                2'd0:    begin scl_n = 1'b1; sda_n = 1'b1; end
                2'd1:    sda_n = 1'b1;
                default: ;
            endcase
            HOLD: begin
                scl_n = 1'b1;
                sda_n = bus.sda_oe;
            end
            default: ;
        endcase

        ack_valid_n = (state_n == ACK) && (q_n == 2'd3) && (cnt_n == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            q             <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            stop_q        <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ack_valid <= 1'b0;
            bus.ack_nack  <= 1'b0;
            bus.scl_oe    <= 1'b0;
            bus.sda_oe    <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
            scl_hist      <= '0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            q             <= q_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            stop_q        <= stop_n;
            bus.in_ready  <= (state_n == IDLE) || (state_n == HOLD);
            bus.busy      <= (state_n != IDLE);
            bus.ack_valid <= ack_valid_n;
            if ((state == ACK) && tick && (q == 2'd1)) bus.ack_nack <= bus.sda_i;
            bus.scl_oe    <= scl_n;
            bus.sda_oe    <= sda_n;
`ifdef I2C_CLK_STRETCH_EN
            scl_hist      <= {scl_hist[0], bus.scl_i};
`endif
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Testbench for i2c_byte_master: bus-level monitor and ACKing slave, checked against a frame-level model.
// Build with I2C_CLK_STRETCH_EN defined to include the clock-stretch scenario.
module tb_i2c_byte_master;
    localparam int unsigned DIV = 4;
    localparam int unsigned PH  = 4 * DIV;

    logic clk = 1'b0;
    logic rst;
    logic slave_pull   = 1'b0;
    logic stretch_pull = 1'b0;

    i2c_byte_master_if bus();
    assign bus.sda_i = ~(bus.sda_oe | slave_pull);
    assign bus.scl_i = ~(bus.scl_oe | stretch_pull);

    i2c_byte_master #(.CLK_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame description consumed by the driver and the reference model.
    logic [7:0] dq[$];
    bit sq[$], pq[$], nq[$];
    bit ack_plan[$];

    // Monitor state
    string ev_s = "";
    string ack_s = "";
    int rcnt = 0, busy_run = 0, last_len = 0, frames_done = 0;
    int hold_ready = 0, hold_bad = 0, stretch_cnt = 0;
    bit stretch_arm = 0, pend = 0, pend_v = 0;
    logic scl_p = 1'b1, sda_p = 1'b1;

    always @(negedge clk) begin
        logic scl_now, sda_now;
        if (rst) begin
            rcnt = 0; slave_pull = 1'b0; stretch_pull = 1'b0; pend = 0;
            scl_p = 1'b1; sda_p = 1'b1; busy_run = 0;
        end else begin
            if (stretch_arm && rcnt == 2 && !scl_p && !bus.scl_oe) begin
                stretch_pull = 1'b1; stretch_cnt = 50; stretch_arm = 0;
            end else if (stretch_pull) begin
                stretch_cnt--;
                if (stretch_cnt == 0) stretch_pull = 1'b0;
            end
            scl_now = !(bus.scl_oe || stretch_pull);
            sda_now = !(bus.sda_oe || slave_pull);
            if (scl_p && scl_now && sda_p && !sda_now) begin
                ev_s = {ev_s, "S"}; rcnt = 0; pend = 0;
            end else if (scl_p && scl_now && !sda_p && sda_now) begin
                ev_s = {ev_s, "P"}; rcnt = 0; pend = 0;
            end
            if (!scl_p && scl_now) begin pend = 1; pend_v = sda_now; end
            if (scl_p && !scl_now && pend) begin
                ev_s = {ev_s, pend_v ? "1" : "0"};
                pend = 0;
                rcnt++;
                if (rcnt == 8) begin
                    if (ack_plan.size() > 0) slave_pull = !ack_plan.pop_front();
                    else slave_pull = 1'b0;
                end else if (rcnt == 9) begin
                    slave_pull = 1'b0; rcnt = 0;
                end
            end
            if (bus.ack_valid) ack_s = {ack_s, bus.ack_nack ? "1" : "0"};
            if (bus.busy) begin
                busy_run++;
                if (bus.in_ready) begin
                    hold_ready++;
                    if (!bus.scl_oe) hold_bad++;
                end
            end else if (busy_run > 0) begin
                last_len = busy_run; busy_run = 0; frames_done++;
            end
            scl_p = scl_now; sda_p = sda_now;
        end
    end

    // Reference model: expected bus events from the frame description.
    function automatic string model_events();
        string s = "";
        for (int i = 0; i < dq.size(); i++) begin
            if (i == 0 || sq[i]) s = {s, "S"};
            s = {s, $sformatf("%08b", dq[i]), nq[i] ? "1" : "0"};
            if (pq[i]) s = {s, "P"};
        end
        return s;
    endfunction

    function automatic string model_acks();
        string s = "";
        foreach (nq[i]) s = {s, nq[i] ? "1" : "0"};
        return s;
    endfunction

    function automatic int model_len();
        int r = 0;
        for (int i = 1; i < sq.size(); i++) if (sq[i]) r++;
        return int'(PH) * (2 + 9 * dq.size() + r);
    endfunction

    // Called at a negedge; returns after the accepting posedge, at the following negedge.
    task automatic offer(input logic [7:0] d, input bit s, input bit p, output bit ok);
        int t = 0;
        ok = 0;
        bus.in_data = d; bus.in_start = s; bus.in_stop = p; bus.in_valid = 1'b1;
        while (!ok && t < 4000) begin
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_start = 1'($urandom);
        bus.in_stop  = 1'($urandom);
        checks++;
        if (!ok) begin errors++; $display("FAIL handshake: no in_ready within %0d cycles", t); end
    endtask

    task automatic wait_done(input int f0);
        int t = 0;
        while (frames_done == f0 && t < 20000) begin @(negedge clk); t++; end
        checks++;
        if (frames_done == f0) begin errors++; $display("FAIL frame_end: busy still high after %0d cycles", t); end
    endtask

    task automatic drive_frame();
        bit ok;
        int f0;
        ev_s = ""; ack_s = ""; hold_ready = 0; hold_bad = 0;
        f0 = frames_done;
        foreach (nq[i]) ack_plan.push_back(nq[i]);
        for (int i = 0; i < dq.size(); i++) offer(dq[i], sq[i], pq[i], ok);
        wait_done(f0);
    endtask

    task automatic clear_frame();
        dq.delete(); sq.delete(); pq.delete(); nq.delete(); ack_plan.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.scl_oe !== 1'b0) begin errors++; $display("FAIL rst_scl_oe: got %b want 0", bus.scl_oe); end
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b want 0", bus.sda_oe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.ack_valid !== 1'b0 || bus.ack_nack !== 1'b0) begin
            errors++; $display("FAIL rst_ack: got %b%b want 00", bus.ack_valid, bus.ack_nack); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_early: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_edge: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_single();
        clear_frame();
        dq.push_back(8'h20); sq.push_back(1); pq.push_back(1); nq.push_back(0);
        drive_frame();
        checks++; if (ev_s != model_events()) begin errors++; $display("FAIL single_events: got %s want %s", ev_s, model_events()); end
        checks++; if (ack_s != "0") begin errors++; $display("FAIL single_ack: got %s want 0", ack_s); end
        checks++; if (last_len != 176) begin errors++; $display("FAIL single_busy_len: got %0d want 176", last_len); end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 8; it++) begin
            int n;
            clear_frame();
            if (it == 0) begin
                dq = '{8'h20, 8'h00, 8'h37}; sq = '{1, 0, 0}; pq = '{0, 0, 1}; nq = '{0, 0, 0};
            end else begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    dq.push_back(8'($urandom));
                    sq.push_back(1'($urandom));
                    pq.push_back(i == n - 1);
                    nq.push_back(1'($urandom));
                end
            end
            drive_frame();
            checks++; if (ev_s != model_events()) begin errors++; $display("FAIL b2b_events[%0d]: got %s want %s", it, ev_s, model_events()); end
            checks++; if (ack_s != model_acks()) begin errors++; $display("FAIL b2b_acks[%0d]: got %s want %s", it, ack_s, model_acks()); end
            checks++; if (last_len != model_len()) begin errors++; $display("FAIL b2b_busy_len[%0d]: got %0d want %0d", it, last_len, model_len()); end
            checks++; if (hold_ready != dq.size() - 1) begin errors++; $display("FAIL b2b_ready_in_frame[%0d]: got %0d want %0d", it, hold_ready, dq.size() - 1); end
            checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold_scl[%0d]: got %0d cycles with SCL released want 0", it, hold_bad); end
        end
    endtask

    task automatic test_repeated_start();
        clear_frame();
        dq = '{8'h20, 8'h5A}; sq = '{1, 1}; pq = '{0, 1}; nq = '{0, 0};
        drive_frame();
        checks++; if (ev_s != "S001000000S010110100P") begin errors++; $display("FAIL rstart_events: got %s want S001000000S010110100P", ev_s); end
        checks++; if (last_len != int'(PH) * 21) begin errors++; $display("FAIL rstart_busy_len: got %0d want %0d", last_len, PH * 21); end
    endtask

    task automatic test_nack_hold();
        bit ok;
        int t = 0, bad = 0, f0;
        logic [7:0] d2;
        clear_frame();
        ev_s = ""; ack_s = "";
        ack_plan.push_back(1);
        f0 = frames_done;
        offer(8'h20, 1, 0, ok);
        while (!(bus.busy && bus.in_ready) && t < 2000) begin @(negedge clk); t++; end
        checks++; if (!(bus.busy && bus.in_ready)) begin errors++; $display("FAIL nack_hold_entry: busy=%b ready=%b want 11", bus.busy, bus.in_ready); end
        checks++; if (ack_s != "1") begin errors++; $display("FAIL nack_pulse: got %s want 1", ack_s); end
        checks++; if (bus.ack_nack !== 1'b1) begin errors++; $display("FAIL nack_value: got %b want 1", bus.ack_nack); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.in_data = 8'($urandom);
            if (!(bus.busy && bus.in_ready && bus.scl_oe)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nack_hold_scl: got %0d bad cycles want 0", bad); end
        d2 = 8'($urandom);
        ack_plan.push_back(0);
        offer(d2, 0, 1, ok);
        wait_done(f0);
        checks++; if (ev_s != {"S001000001", $sformatf("%08b", d2), "0P"}) begin
            errors++; $display("FAIL nack_events: got %s want S001000001%08b0P", ev_s, d2); end
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        int diff;
        clear_frame();
        dq.push_back(8'hC3); sq.push_back(1); pq.push_back(1); nq.push_back(0);
        stretch_arm = 1;
        drive_frame();
        diff = last_len - model_len() - 50;
        checks++; if (diff < -2 || diff > 2) begin errors++; $display("FAIL stretch_len: got %0d want %0d +/- 2", last_len, model_len() + 50); end
        checks++; if (ev_s != model_events()) begin errors++; $display("FAIL stretch_events: got %s want %s", ev_s, model_events()); end
    endtask
`endif

    task automatic test_mid_reset();
        bit ok;
        int t = 0;
        clear_frame();
        ev_s = "";
        ack_plan.push_back(0);
        offer(8'h00, 1, 1, ok);
        while (!(rcnt == 4 && bus.scl_oe && bus.sda_oe) && t < 2000) begin @(negedge clk); t++; end
        checks++; if (!(rcnt == 4 && bus.scl_oe)) begin errors++; $display("FAIL midrst_reach_bit4: got bit %0d want 4", rcnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin
            errors++; $display("FAIL midrst_release: got scl_oe=%b sda_oe=%b want 00", bus.scl_oe, bus.sda_oe); end
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got busy=%b ready=%b want 00", bus.busy, bus.in_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ack_plan.delete();
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_early: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_edge: got %b want 1", bus.in_ready); end
        @(negedge clk);
        clear_frame();
        dq.push_back(8'hA5); sq.push_back(0); pq.push_back(1); nq.push_back(0);
        drive_frame();
        checks++; if (ev_s != model_events()) begin errors++; $display("FAIL midrst_recover: got %s want %s", ev_s, model_events()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_start = 1'b0; bus.in_stop = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_repeated_start();
        test_nack_hold();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
